// File: rtl/seg_scan_decoder.sv
// rtl/seg_scan_decoder.sv - rebuilds per-digit hex values from a scanned 7-segment bus
// with a stability filter and sticky code/anode fault flags.
module seg_scan_decoder #(
  parameter int NUM_DIGITS     = 4,
  parameter int STABLE_CYCLES  = 3,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_DIGITS-1:0]   an,
  input  logic [6:0]              seg,
  input  logic                    clr_err,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic [NUM_DIGITS-1:0]   digit_valid,
  output logic                    update,
  output logic [NUM_DIGITS-1:0]   err_digit,
  output logic                    multi_err,
  output logic                    err_any
);

  localparam logic [NUM_DIGITS-1:0] AN_IDLE  = (AN_ACTIVE_LOW != 0) ? '1 : '0;
  localparam logic [6:0]            SEG_IDLE = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic [7:0]            STABLE   = 8'(STABLE_CYCLES);
  localparam logic [NUM_DIGITS-1:0] AN_ONE   = NUM_DIGITS'(1);

  logic [NUM_DIGITS-1:0] an_q, prev_an, an_n;
  logic [6:0]            seg_q, prev_seg, seg_n;
  logic [7:0]            cnt, cnt_next;
  logic                  done, done_eff;
  logic                  changed, one_hot, multi, capture;
  logic                  code_valid, code_blank;
  logic [3:0]            code_val;

  always_comb begin
    an_n     = (AN_ACTIVE_LOW != 0) ? ~an_q : an_q;
    seg_n    = (SEG_ACTIVE_LOW != 0) ? seg_q : ~seg_q;
    changed  = (an_q != prev_an) || (seg_q != prev_seg);
    one_hot  = (an_n != '0) && ((an_n & (an_n - AN_ONE)) == '0);
    multi    = (an_n != '0) && !one_hot;
    cnt_next = '0;
    if (one_hot) begin
      if (changed)
        cnt_next = 8'd1;
      else if (cnt >= STABLE)
        cnt_next = cnt;
      else
        cnt_next = cnt + 8'd1;
    end
    // A new sample opens a new dwell, so any earlier capture no longer blocks.
    done_eff = changed ? 1'b0 : done;
    capture  = one_hot && (cnt_next == STABLE) && !done_eff;
  end

  always_comb begin
    code_valid = 1'b1;
    code_blank = 1'b0;
    code_val   = 4'h0;
    case (seg_n)
      7'h40: code_val = 4'h0;
      7'h79: code_val = 4'h1;
      7'h24: code_val = 4'h2;
      7'h30: code_val = 4'h3;
      7'h19: code_val = 4'h4;
      7'h12: code_val = 4'h5;
      7'h02: code_val = 4'h6;
      7'h78: code_val = 4'h7;
      7'h00: code_val = 4'h8;
      7'h10: code_val = 4'h9;
      7'h08: code_val = 4'hA;
      7'h03: code_val = 4'hB;
      7'h46: code_val = 4'hC;
      7'h21: code_val = 4'hD;
      7'h06: code_val = 4'hE;
      7'h0E: code_val = 4'hF;
      7'h7F: begin
        code_valid = 1'b0;
        code_blank = 1'b1;
      end
      default: code_valid = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      an_q        <= AN_IDLE;
      seg_q       <= SEG_IDLE;
      prev_an     <= AN_IDLE;
      prev_seg    <= SEG_IDLE;
      cnt         <= '0;
      done        <= 1'b0;
      digits      <= '0;
      digit_valid <= '0;
      update      <= 1'b0;
      err_digit   <= '0;
      multi_err   <= 1'b0;
    end else begin
      an_q     <= an;
      seg_q    <= seg;
      prev_an  <= an_q;
      prev_seg <= seg_q;
      cnt      <= cnt_next;
      done     <= one_hot ? (done_eff || capture) : 1'b0;
      update   <= capture && code_valid;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (capture && an_n[i]) begin
          if (code_valid) begin
            digits[4*i +: 4] <= code_val;
            digit_valid[i]   <= 1'b1;
          end else begin
            digit_valid[i]   <= 1'b0;
          end
        end
      end
      // Clear first, then OR in new events so a same-edge set survives clr_err.
      err_digit <= (clr_err ? '0 : err_digit)
                 | ({NUM_DIGITS{capture && !code_valid && !code_blank}} & an_n);
      multi_err <= (multi_err && !clr_err) || multi;
    end
  end

  assign err_any = (|err_digit) | multi_err;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// tb/tb_seg_scan_decoder.sv - scoreboard bench for seg_scan_decoder
module tb_seg_scan_decoder;

  logic        clk = 1'b0;
  logic        rst, clr_err;
  logic [3:0]  an, an_b;
  logic [6:0]  seg, seg_b;
  logic [15:0] digits, digits_b;
  logic [3:0]  digit_valid, err_digit, digit_valid_b, err_digit_b;
  logic        update, multi_err, err_any, update_b, multi_err_b, err_any_b;

  always #5 clk = ~clk;

  seg_scan_decoder #(.NUM_DIGITS(4), .STABLE_CYCLES(3), .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)) dut (
    .clk(clk), .rst(rst), .an(an), .seg(seg), .clr_err(clr_err),
    .digits(digits), .digit_valid(digit_valid), .update(update),
    .err_digit(err_digit), .multi_err(multi_err), .err_any(err_any)
  );

  seg_scan_decoder #(.NUM_DIGITS(4), .STABLE_CYCLES(3), .SEG_ACTIVE_LOW(0), .AN_ACTIVE_LOW(1)) dut_hi (
    .clk(clk), .rst(rst), .an(an_b), .seg(seg_b), .clr_err(clr_err),
    .digits(digits_b), .digit_valid(digit_valid_b), .update(update_b),
    .err_digit(err_digit_b), .multi_err(multi_err_b), .err_any(err_any_b)
  );

  typedef struct packed {
    logic [15:0] d;
    logic [3:0]  v;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [15:0] exp_digits;
  logic [3:0]  exp_valid;
  int          errors = 0;
  int          checks = 0;
  int          upd_count = 0;
  int          upd_before;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic drive(input logic [3:0] a, input logic [6:0] s, input int n);
    an  = a;
    seg = s;
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_cap(input int idx, input logic [3:0] val);
    exp_digits[4*idx +: 4] = val;
    exp_valid[idx]         = 1'b1;
    exp_q.push_back({exp_digits, exp_valid});
  endtask

  always @(negedge clk) begin
    if (!rst && update === 1'b1) begin
      upd_count++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_update: got digits=%0h valid=%0h expected no update", digits, digit_valid);
      end else begin
        mon_e = exp_q.pop_front();
        check("upd_digits", {16'h0, digits}, {16'h0, mon_e.d});
        check("upd_valid", {28'h0, digit_valid}, {28'h0, mon_e.v});
      end
    end
  end

  initial begin
    rst = 1'b1; clr_err = 1'b0;
    an = 4'hF; seg = 7'h7F;
    an_b = 4'hF; seg_b = 7'h00;
    exp_digits = '0; exp_valid = '0;
    repeat (2) @(negedge clk);
    check("rst_digits", {16'h0, digits}, 32'h0);
    check("rst_valid", {28'h0, digit_valid}, 32'h0);
    check("rst_update", {31'h0, update}, 32'h0);
    check("rst_errs", {26'h0, err_digit, multi_err, err_any}, 32'h0);
    rst = 1'b0;

    // 1: single digit capture latency
    expect_cap(0, 4'h2);
    drive(4'b1110, 7'h24, 4);
    check("t1_update_at_edge4", {31'h0, update}, 32'h1);
    drive(4'b1111, 7'h7F, 2);

    // 2: full scan
    upd_before = upd_count;
    expect_cap(0, 4'h1); drive(4'b1110, 7'h79, 8);
    expect_cap(1, 4'hA); drive(4'b1101, 7'h08, 8);
    expect_cap(2, 4'hF); drive(4'b1011, 7'h0E, 8);
    expect_cap(3, 4'h0); drive(4'b0111, 7'h40, 8);
    check("t2_digits", {16'h0, digits}, 32'h0FA1);
    check("t2_valid", {28'h0, digit_valid}, 32'hF);
    check("t2_pulses", upd_count - upd_before, 32'd4);

    // 3: mid-dwell change discards partial dwell
    drive(4'b1101, 7'h79, 2);
    expect_cap(1, 4'h3);
    drive(4'b1101, 7'h30, 4);
    check("t3_update_at_edge4", {31'h0, update}, 32'h1);
    check("t3_digit1", {28'h0, digits[7:4]}, 32'h3);

    // 4: invalid code, clr_err racing a new invalid capture
    drive(4'b1011, 7'h7E, 4);
    exp_valid[2] = 1'b0;
    check("t4_err_digit", {28'h0, err_digit}, 32'h4);
    check("t4_err_any", {31'h0, err_any}, 32'h1);
    check("t4_valid", {28'h0, digit_valid}, {28'h0, exp_valid});
    check("t4_digit2", {28'h0, digits[11:8]}, 32'hF);
    drive(4'b1011, 7'h7D, 3);
    clr_err = 1'b1;
    drive(4'b1011, 7'h7D, 1);
    clr_err = 1'b0;
    check("t4_set_wins", {28'h0, err_digit}, 32'h4);
    clr_err = 1'b1;
    drive(4'b1111, 7'h7F, 1);
    clr_err = 1'b0;
    check("t4_clr", {26'h0, err_digit, multi_err, err_any}, 32'h0);

    // 5: multiple anodes, then blank
    drive(4'b1100, 7'h40, 4);
    check("t5_multi_err", {31'h0, multi_err}, 32'h1);
    check("t5_err_any", {31'h0, err_any}, 32'h1);
    drive(4'b1101, 7'h7F, 4);
    exp_valid[1] = 1'b0;
    check("t5_valid", {28'h0, digit_valid}, {28'h0, exp_valid});
    check("t5_err_digit", {28'h0, err_digit}, 32'h0);
    check("t5_digits", {16'h0, digits}, 32'h0F31);

    // 6: reset mid-dwell
    drive(4'b1110, 7'h12, 2);
    upd_before = upd_count;
    rst = 1'b1;
    @(negedge clk);
    check("t6_rst_digits", {16'h0, digits}, 32'h0);
    check("t6_rst_state", {22'h0, digit_valid, err_digit, multi_err, err_any}, 32'h0);
    rst = 1'b0;
    drive(4'b1110, 7'h12, 2);
    drive(4'b1111, 7'h7F, 3);
    check("t6_no_update", upd_count - upd_before, 32'd0);
    check("t6_digits", {16'h0, digits}, 32'h0);

    // active-high segment build
    an_b = 4'b1110; seg_b = 7'h5B;
    repeat (4) @(negedge clk);
    check("hi_update", {31'h0, update_b}, 32'h1);
    check("hi_digit0", {28'h0, digits_b[3:0]}, 32'h2);
    check("hi_valid", {28'h0, digit_valid_b}, 32'h1);

    check("queue_drained", exp_q.size(), 32'd0);
    check("total_updates", upd_count, 32'd6);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
